// File: rtl/pixie_pkg.sv
// Shared definitions for the pixie DMA engine: CPU state codes and line-repeat encoding.
package pixie_pkg;

    // CPU state codes presented on sc
    localparam logic [1:0] SC_FETCH = 2'b00;
    localparam logic [1:0] SC_EXEC  = 2'b01;
    localparam logic [1:0] SC_DMA   = 2'b10;
    localparam logic [1:0] SC_INT   = 2'b11;

    // Line-repeat selection: each source row is shown 2^sel times
    typedef enum logic [1:0] {
        REP_X1 = 2'd0,
        REP_X2 = 2'd1,
        REP_X4 = 2'd2,
        REP_X8 = 2'd3
    } rep_sel_e;

    // Width of the completed-lines counter inside a repeat group (max 7 completed)
    localparam int unsigned REP_CNT_W = 3;

    // Number of display lines in one repeat group
    function automatic logic [REP_CNT_W:0] rep_lines(input logic [1:0] sel);
        return 4'd1 << sel;
    endfunction

endpackage

// File: rtl/pixie_raster_timer.sv
// Raster timer: horizontal/vertical machine-cycle counters and per-line window flags.
// Window flags are registered on the line wrap and describe the line being entered.
module pixie_raster_timer #(
    parameter int unsigned BYTES_PER_LINE  = 14,
    parameter int unsigned LINES_PER_FRAME = 262,
    parameter int unsigned ACTIVE_START    = 80,
    parameter int unsigned ACTIVE_LINES    = 128,
    parameter int unsigned HCNT_W          = 4,
    parameter int unsigned VCNT_W          = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_enable,
    input  logic              enabled,
    output logic [HCNT_W-1:0] hcnt,
    output logic              line_wrap_c,
    output logic              frame_wrap_c,
    output logic              line_start_c,
    output logic              efx,
    output logic              intr,
    output logic              v_active,
    output logic              frame_start
);

    localparam int unsigned WW = VCNT_W + 1;

    localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(BYTES_PER_LINE - 1);
    localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(LINES_PER_FRAME - 1);
    localparam logic [WW-1:0]     ACT_LO  = WW'(ACTIVE_START);
    localparam logic [WW-1:0]     ACT_HI  = WW'(ACTIVE_START + ACTIVE_LINES);
    localparam logic [WW-1:0]     EFX_A   = WW'(ACTIVE_START - 4);
    localparam logic [WW-1:0]     EFX_B   = WW'(ACTIVE_START + ACTIVE_LINES - 4);
    localparam logic [WW-1:0]     INTR_LO = WW'(ACTIVE_START - 2);

    logic [VCNT_W-1:0] vcnt;
    logic [VCNT_W-1:0] vcnt_next;
    logic [WW-1:0]     vx;
    logic              in_act;
    logic              in_efx;
    logic              in_intr;

    // Wrap detection and window decode for the upcoming line
    always_comb begin
        line_wrap_c  = clk_enable && (hcnt == H_LAST);
        frame_wrap_c = line_wrap_c && (vcnt == V_LAST);
        vcnt_next    = (vcnt == V_LAST) ? '0 : vcnt + VCNT_W'(1);
        vx           = {1'b0, vcnt_next};
        in_act       = (vx >= ACT_LO) && (vx < ACT_HI);
        in_efx       = ((vx >= EFX_A) && (vx < ACT_LO)) || ((vx >= EFX_B) && (vx < ACT_HI));
        in_intr      = (vx >= INTR_LO) && (vx < ACT_LO);
        line_start_c = line_wrap_c && enabled && in_act;
    end

    // Raster counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (clk_enable) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= vcnt_next;
            end else begin
                hcnt <= hcnt + HCNT_W'(1);
            end
        end
    end

    // Per-line window flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            efx      <= 1'b0;
            intr     <= 1'b0;
            v_active <= 1'b0;
        end else if (line_wrap_c) begin
            efx      <= in_efx;
            intr     <= enabled && in_intr;
            v_active <= enabled && in_act;
        end
    end

    // One-clock pulse after the frame wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap_c;
        end
    end

endmodule

// File: rtl/pixie_dma_engine.sv
// Pixie-style display DMA engine: raster timing, DMA request window and
// frame-buffer write addressing with line repeat.
// Optional feature macro: PIXIE_DMA_OVERRUN_EN (sticky flag for DMA cycles
// outside the request window); without it dma_overrun is tied low.
module pixie_dma_engine
    import pixie_pkg::*;
#(
    parameter int unsigned BYTES_PER_LINE  = 14,
    parameter int unsigned LINES_PER_FRAME = 262,
    parameter int unsigned ACTIVE_START    = 80,
    parameter int unsigned ACTIVE_LINES    = 128,
    parameter int unsigned DMA_START_COL   = 1,
    parameter int unsigned DMA_BYTES       = 8,
    parameter int unsigned ADDR_W          = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_enable,
    input  logic [1:0]        sc,
    input  logic              disp_on,
    input  logic              disp_off,
    input  logic [1:0]        repeat_sel,
    input  logic [7:0]        data,
    output logic              dmao,
    output logic              intr,
    output logic              efx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr_en,
    output logic              frame_start,
    output logic              dma_overrun
);

    localparam int unsigned HCNT_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam int unsigned VCNT_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam int unsigned HW     = HCNT_W + 1;

    localparam logic [HW-1:0] COL_LO = HW'(DMA_START_COL);
    localparam logic [HW-1:0] COL_HI = HW'(DMA_START_COL + DMA_BYTES);

    logic [HCNT_W-1:0]    hcnt;
    logic                 line_wrap;
    logic                 frame_wrap;
    logic                 line_start;
    logic                 v_active;
    logic                 enabled;
    logic                 enabled_now;
    logic                 col_hit;
    logic                 dma_xfer;

    logic [ADDR_W-1:0]    addr_cnt;
    logic [ADDR_W-1:0]    addr_next;
    logic [ADDR_W-1:0]    line_base;
    logic [REP_CNT_W-1:0] rep_cnt;
    logic [REP_CNT_W-1:0] rep_next;
    logic [REP_CNT_W:0]   rep_done;
    rep_sel_e             rep_sel_q;
    logic                 line_end;
    logic                 reload;

    pixie_raster_timer #(
        .BYTES_PER_LINE  (BYTES_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .ACTIVE_START    (ACTIVE_START),
        .ACTIVE_LINES    (ACTIVE_LINES),
        .HCNT_W          (HCNT_W),
        .VCNT_W          (VCNT_W)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk_enable   (clk_enable),
        .enabled      (enabled),
        .hcnt         (hcnt),
        .line_wrap_c  (line_wrap),
        .frame_wrap_c (frame_wrap),
        .line_start_c (line_start),
        .efx          (efx),
        .intr         (intr),
        .v_active     (v_active),
        .frame_start  (frame_start)
    );

    // Display enable; disp_on wins over a simultaneous disp_off
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enabled <= 1'b0;
        end else if (clk_enable) begin
            if (disp_on) begin
                enabled <= 1'b1;
            end else if (disp_off) begin
                enabled <= 1'b0;
            end
        end
    end

    // DMA request window and frame-buffer write port
    always_comb begin
        // a disp_off strobe removes the request in the very cycle it arrives
        enabled_now = enabled && !(clk_enable && disp_off && !disp_on);
        col_hit     = ({1'b0, hcnt} >= COL_LO) && ({1'b0, hcnt} < COL_HI);
        dmao        = enabled_now && v_active && col_hit;
        dma_xfer    = clk_enable && enabled && (sc == SC_DMA);
        mem_wr_en   = dma_xfer;
        mem_data    = data;
        mem_addr    = addr_cnt;
    end

    // Next address / repeat state: frame wrap > repeat reload > DMA increment
    always_comb begin
        addr_next = addr_cnt;
        rep_next  = rep_cnt;
        line_end  = line_wrap && v_active && enabled;
        rep_done  = {1'b0, rep_cnt} + 4'd1;
        reload    = line_end && (rep_done < rep_lines(rep_sel_q));
        if (frame_wrap) begin
            addr_next = '0;
            rep_next  = '0;
        end else if (reload) begin
            addr_next = line_base;
            rep_next  = rep_done[REP_CNT_W-1:0];
        end else begin
            if (line_end) begin
                rep_next = '0;
            end
            if (dma_xfer) begin
                addr_next = addr_cnt + ADDR_W'(1);
            end
        end
    end

    // Address, line base and repeat-group registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_cnt  <= '0;
            line_base <= '0;
            rep_cnt   <= '0;
            rep_sel_q <= REP_X1;
        end else begin
            addr_cnt <= addr_next;
            rep_cnt  <= rep_next;
            if (line_start) begin
                line_base <= addr_next;
                if (rep_next == '0) begin
                    rep_sel_q <= rep_sel_e'(repeat_sel);
                end
            end
        end
    end

`ifdef PIXIE_DMA_OVERRUN_EN
    // Sticky flag: DMA cycle taken while no request was outstanding
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_overrun <= 1'b0;
        end else if (clk_enable && disp_on) begin
            dma_overrun <= 1'b0;
        end else if (dma_xfer && !dmao) begin
            dma_overrun <= 1'b1;
        end
    end
`else
    assign dma_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_pixie_dma_engine.sv
// Self-checking bench for pixie_dma_engine: scoreboard of expected frame-buffer
// writes, raster window checks, disp_off, async reset, overrun flag and a
// second instance with a non-default raster geometry.
module tb_pixie_dma_engine;
    import pixie_pkg::*;

`ifdef PIXIE_DMA_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk;
    logic       reset_n;
    logic       clk_enable;
    logic [1:0] sc;
    logic       disp_on;
    logic       disp_off;
    logic [1:0] repeat_sel;
    logic [7:0] data;
    logic       dmao, intr, efx, mem_wr_en, frame_start, dma_overrun;
    logic [9:0] mem_addr;
    logic [7:0] mem_data;

    logic       ce2, on2;
    logic       off2;
    logic [1:0] sc2, rsel2;
    logic [7:0] data2;
    logic       dmao2, intr2, efx2, mem_wr_en2, frame_start2, dma_overrun2;
    logic [9:0] mem_addr2;
    logic [7:0] mem_data2;

    int   vectors;
    int   miscompares;
    wr_t  sb[$];
    logic en_m;
    logic ovr_m;
    logic wrapped;
    int   last_addr;

    pixie_dma_engine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_enable  (clk_enable),
        .sc          (sc),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .repeat_sel  (repeat_sel),
        .data        (data),
        .dmao        (dmao),
        .intr        (intr),
        .efx         (efx),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wr_en   (mem_wr_en),
        .frame_start (frame_start),
        .dma_overrun (dma_overrun)
    );

    pixie_dma_engine #(
        .BYTES_PER_LINE  (16),
        .LINES_PER_FRAME (312),
        .DMA_BYTES       (12)
    ) dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_enable  (ce2),
        .sc          (sc2),
        .disp_on     (on2),
        .disp_off    (off2),
        .repeat_sel  (rsel2),
        .data        (data2),
        .dmao        (dmao2),
        .intr        (intr2),
        .efx         (efx2),
        .mem_addr    (mem_addr2),
        .mem_data    (mem_data2),
        .mem_wr_en   (mem_wr_en2),
        .frame_start (frame_start2),
        .dma_overrun (dma_overrun2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One full frame from (0,0); optional early return at (rst_v,rst_h)
    task automatic run_frame(input int rmode, input int off_v, input int off_h,
                             input int ovr_v, input int rst_v, input int rst_h,
                             input logic on_first);
        int rsh;
        rsh = (rmode == 2) ? 2 : 0;
        for (int v = 0; v < 262; v++) begin
            for (int h = 0; h < 14; h++) begin
                logic on_c, off_c, act, exp_dmao, exp_intr, exp_efx;
                wr_t  w, got;
                if (v == rst_v && h == rst_h) return;
                @(negedge clk);
                on_c     = on_first && (v == 0) && (h == 0);
                off_c    = (v == off_v) && (h == off_h);
                act      = (v >= 80) && (v < 208);
                exp_dmao = en_m && !off_c && act && (h >= 1) && (h <= 8);
                exp_intr = en_m && (v == 78 || v == 79);
                exp_efx  = (v >= 76 && v < 80) || (v >= 204 && v < 208);
                clk_enable = 1'b1;
                disp_on    = on_c;
                disp_off   = off_c;
                repeat_sel = (rmode == 2 && h == 13 && v >= 79 && v < 207 && ((v - 79) % 4 == 0)) ? 2'd2 : 2'd0;
                data       = 8'($urandom_range(0, 255));
                if (exp_dmao)                          sc = SC_DMA;
                else if (v == ovr_v && h == 12)        sc = SC_DMA;
                else if (off_v >= 0 && v > off_v && h == 5) sc = SC_DMA;
                else if (h == 10)                      sc = SC_INT;
                else                                   sc = (h % 2 == 1) ? SC_EXEC : SC_FETCH;
                if (sc == SC_DMA && en_m) begin
                    if (exp_dmao) w.addr = 10'(((((v - 80) >> rsh) * 8) + h - 1) % 1024);
                    else          w.addr = 10'(((128 >> rsh) * 8) % 1024);
                    w.data = data;
                    sb.push_back(w);
                end
                #1;
                check("dmao", 32'(dmao), 32'(exp_dmao));
                check("intr", 32'(intr), 32'(exp_intr));
                check("efx", 32'(efx), 32'(exp_efx));
                check("frame_start", 32'(frame_start), 32'(wrapped && v == 0 && h == 0));
                check("dma_overrun", 32'(dma_overrun), 32'(ovr_m));
                if (mem_wr_en) begin
                    if (sb.size() == 0) begin
                        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                    end else begin
                        got = sb.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(got.addr));
                        check("wr_data", 32'(mem_data), 32'(got.data));
                        last_addr = int'(mem_addr);
                    end
                end
                if (on_c) begin
                    en_m  = 1'b1;
                    ovr_m = 1'b0;
                end else begin
                    if (sc == SC_DMA && en_m && !exp_dmao) ovr_m = OVR_EN;
                    if (off_c) en_m = 1'b0;
                end
            end
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        wrapped = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dmao"}, 32'(dmao), 32'd0);
        check({tag, "_intr"}, 32'(intr), 32'd0);
        check({tag, "_efx"}, 32'(efx), 32'd0);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_ovr"}, 32'(dma_overrun), 32'd0);
        check({tag, "_wr"}, 32'(mem_wr_en), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    endtask

    initial begin
        int   applied;
        logic found;
        vectors = 0; miscompares = 0;
        en_m = 1'b0; ovr_m = 1'b0; wrapped = 1'b0; last_addr = -1;
        reset_n = 1'b0; clk_enable = 1'b0; sc = SC_DMA; disp_on = 1'b0; disp_off = 1'b0;
        repeat_sel = 2'd0; data = 8'h00;
        ce2 = 1'b0; on2 = 1'b0; off2 = 1'b0; sc2 = SC_FETCH; rsel2 = 2'd0; data2 = 8'h5A;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        sc = SC_FETCH;
        reset_n = 1'b1;

        // x1 repeat: 1024 writes, last address 1023
        last_addr = -1;
        run_frame(0, -1, -1, -1, -1, -1, 1'b1);
        check("last_addr_x1", 32'(last_addr), 32'd1023);

        // x4 repeat with repeat_sel only valid at group starts
        last_addr = -1;
        run_frame(2, -1, -1, -1, -1, -1, 1'b0);
        check("last_addr_x4", 32'(last_addr), 32'd255);

        // disp_off at line 120, hcnt 3, stray DMA cycles afterwards
        run_frame(0, 120, 3, -1, -1, -1, 1'b0);

        // async reset at line 150, hcnt 5
        run_frame(0, -1, -1, -1, 150, 5, 1'b1);
        @(negedge clk);
        #1;
        check("pre_reset_dmao", 32'(dmao), 32'd1);
        clk_enable = 1'b1;
        sc = SC_DMA;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        clk_enable = 1'b0;
        sc = SC_FETCH;
        sb.delete();
        en_m = 1'b0; ovr_m = 1'b0; wrapped = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // frame period after reset, with clk_enable every other clock
        applied = 0;
        found = 1'b0;
        for (int c = 0; c < 10000 && !found; c++) begin
            @(negedge clk);
            #1;
            if (frame_start) begin
                found = 1'b1;
                clk_enable = 1'b0;
            end else begin
                clk_enable = (c % 2 == 1);
                if (clk_enable) applied++;
            end
        end
        check("frame_start_seen", 32'(found), 32'd1);
        check("frame_period", 32'(applied), 32'd3668);
        wrapped = 1'b0;

        // overrun at line 210, hcnt 12; cleared by disp_on in the next frame
        run_frame(0, -1, -1, 210, -1, -1, 1'b1);
        check("ovr_after_frame", 32'(dma_overrun), 32'(OVR_EN));
        run_frame(0, -1, -1, -1, -1, -1, 1'b1);
        check("ovr_cleared", 32'(dma_overrun), 32'd0);

        // non-default geometry: 16 cycles/line, 12 DMA bytes, 312 lines
        for (int c = 0; c < 2 * 4992; c++) begin
            int   h2, v2;
            logic e2;
            @(negedge clk);
            clk_enable = 1'b0;
            ce2 = 1'b1;
            on2 = (c == 0);
            h2 = c % 16;
            v2 = (c / 16) % 312;
            e2 = (c > 0);
            #1;
            check("dmao2", 32'(dmao2), 32'(e2 && v2 >= 80 && v2 < 208 && h2 >= 1 && h2 <= 12));
            check("fs2", 32'(frame_start2), 32'(c == 4992));
            check("efx2", 32'(efx2), 32'((v2 >= 76 && v2 < 80) || (v2 >= 204 && v2 < 208)));
            check("intr2", 32'(intr2), 32'(e2 && (v2 == 78 || v2 == 79)));
            check("wr2", 32'(mem_wr_en2), 32'd0);
        end
        ce2 = 1'b0;
        on2 = 1'b0;
        #1;
        check("addr2", 32'(mem_addr2), 32'd0);
        check("data2", 32'(mem_data2), 32'h5A);
        check("ovr2", 32'(dma_overrun2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
